shift_operand_stage: RTL and testbench
======================================

Name: shift_operand_stage

Overview:
- ID/EX pipeline stage directly upstream of the 16-bit barrel shifter.
- Registers decoded shift instructions and selects the shift amount (register Rt[3:0] or 4-bit immediate).
- Applies EX/MEM and MEM/WB forwarding to the registered operands.
- Drives the shifter's data, amount and 2-bit operation inputs; honours stall and flush from the hazard unit.

Parameters:
- DATA_W, 16, operand width; the shifter is fixed at 16, no other value is supported.
- REG_AW, 3, register-address width (8 GPRs; R0 is a normal register, not hard-wired zero).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold the stage register contents
- flush  in  1  squash: next stage contents become a bubble
- inValid  in  1  decode stage presents a shift instruction this cycle
- inOp  in  2  00 rotate-left, 01 shift-left-logical, 10 rotate-right, 11 shift-right-logical
- inRsAddr  in  3  source register of the data operand
- inRtAddr  in  3  source register of the amount operand
- inRdAddr  in  3  destination register
- inRsData  in  16  register-file read of Rs
- inRtData  in  16  register-file read of Rt
- inImm  in  4  immediate shift amount
- inUseImm  in  1  1 = amount from inImm, 0 = amount from Rt[3:0]
- exMemWrEn  in  1  EX/MEM instruction writes a register
- exMemRd  in  3  EX/MEM destination register
- exMemData  in  16  EX/MEM result
- memWbWrEn  in  1  MEM/WB instruction writes a register
- memWbRd  in  3  MEM/WB destination register
- memWbData  in  16  MEM/WB write-back data
- outValid  out  1  stage holds a live instruction
- shData  out  16  to shifter dataIn
- shAmount  out  4  to shifter shiftAmount
- shOp  out  2  to shifter operation
- outRd  out  3  destination register, passed toward EX/MEM
- fwdSel  out  4  debug: {rsSel[1:0], rtSel[1:0]}; 00 none, 01 MEM/WB, 10 EX/MEM

Behaviour:
- Stage register fields: valid, op, rsAddr, rtAddr, rdAddr, rsData, rtData, imm, useImm.
- rst_n low, asynchronously: every field clears to 0, so outValid=0 and all outputs are 0.
- Update on each rising clk, in priority order:
  1. flush=1: valid<=0; other fields don't-care.
  2. Else stall=1: all fields hold their values.
  3. Else: all fields load from in* and valid<=inValid.
- Flush beats stall when both are asserted.
- Latency: an instruction accepted at edge N drives shifter inputs during cycle N+1. The stage is combinational from register to outputs.
- Forwarding (combinational, evaluated every cycle on the registered addresses):
  - rs: if exMemWrEn and exMemRd==rsAddr, use exMemData.
  - Else if memWbWrEn and memWbRd==rsAddr, use memWbData.
  - Else use the registered rsData.
  - rt is resolved identically.
  - EX/MEM has priority over MEM/WB when both match.
- Forwarding is re-evaluated during a stall. A held instruction picks up a producer that reaches EX/MEM or MEM/WB while stalled.
- Write-back is not captured into the stage register. The source must still be visible on the forwarding ports in the cycle the stage drives it.
- Amount selection: shAmount = useImm ? imm : fwdRt[3:0]. Rt[15:4] is ignored.
- With useImm=1 there is no Rt dependency, and fwdSel.rt reports 00.
- Outputs when valid=1: shData=fwdRs, shOp=op, outRd=rdAddr, outValid=1.
- Outputs when valid=0: shData, shAmount, shOp, outRd and fwdSel are all forced to 0.
- Rs==Rt in one instruction: both operands take the same forwarded value.
- No arithmetic is performed; widths pass through unchanged.

Test Plan:
- Reset: assert rst_n=0 mid-cycle while valid=1 -> outValid, shData, shAmount, shOp, outRd all drop to 0 immediately, without waiting for a clock edge. Release, then no input -> outputs stay 0.
- Plain capture: inValid=1, op=01, Rs data 0x00F3, inUseImm=1, imm=4, rd=5, no forwarding -> next cycle shData=0x00F3, shAmount=4, shOp=01, outRd=5, fwdSel=0000.
- Priority forwarding: stage holds rs=R2, rt=R3, useImm=0; exMemWrEn=1, exMemRd=2, exMemData=0xA5A5; memWbWrEn=1, memWbRd=2 and 3, memWbData=0x1237 -> shData=0xA5A5, shAmount=7, fwdSel=1001.
- Stall: load op=10, Rs=0x8001, amount=1, then stall=1 for 3 cycles while inputs change -> outputs unchanged. Mid-stall, EX/MEM writes the Rs register with 0x0F0F -> shData switches to 0x0F0F in that same cycle.
- Flush vs stall: flush=1 and stall=1 on the same edge with valid=1 -> outValid=0 and all outputs 0 next cycle; a subsequent clean load resumes normally.
- Immediate ignores Rt hazard: useImm=1, imm=15, EX/MEM writes the Rt register with 0x0003 -> shAmount=15, fwdSel[1:0]=00.

Source files
------------

// File: rtl/shift_operand_stage.sv
// ID/EX register feeding the 16-bit barrel shifter: captures decoded shift
// instructions, resolves EX/MEM and MEM/WB forwarding, and selects the amount.
module shift_operand_stage #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              inValid,
  input  logic [1:0]        inOp,
  input  logic [REG_AW-1:0] inRsAddr,
  input  logic [REG_AW-1:0] inRtAddr,
  input  logic [REG_AW-1:0] inRdAddr,
  input  logic [DATA_W-1:0] inRsData,
  input  logic [DATA_W-1:0] inRtData,
  input  logic [3:0]        inImm,
  input  logic              inUseImm,
  input  logic              exMemWrEn,
  input  logic [REG_AW-1:0] exMemRd,
  input  logic [DATA_W-1:0] exMemData,
  input  logic              memWbWrEn,
  input  logic [REG_AW-1:0] memWbRd,
  input  logic [DATA_W-1:0] memWbData,
  output logic              outValid,
  output logic [DATA_W-1:0] shData,
  output logic [3:0]        shAmount,
  output logic [1:0]        shOp,
  output logic [REG_AW-1:0] outRd,
  output logic [3:0]        fwdSel
);

  localparam logic [1:0] FWD_NONE  = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  logic              valid_q,   valid_d;
  logic [1:0]        op_q,      op_d;
  logic [REG_AW-1:0] rs_addr_q, rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q, rt_addr_d;
  logic [REG_AW-1:0] rd_addr_q, rd_addr_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [3:0]        imm_q,     imm_d;
  logic              use_imm_q, use_imm_d;

  // Flush outranks stall; non-valid fields are left loaded on flush.
  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    rs_addr_d = rs_addr_q;
    rt_addr_d = rt_addr_q;
    rd_addr_d = rd_addr_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    use_imm_d = use_imm_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      valid_d   = inValid;
      op_d      = inOp;
      rs_addr_d = inRsAddr;
      rt_addr_d = inRtAddr;
      rd_addr_d = inRdAddr;
      rs_data_d = inRsData;
      rt_data_d = inRtData;
      imm_d     = inImm;
      use_imm_d = inUseImm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      rs_addr_q <= '0;
      rt_addr_q <= '0;
      rd_addr_q <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      use_imm_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      rs_addr_q <= rs_addr_d;
      rt_addr_q <= rt_addr_d;
      rd_addr_q <= rd_addr_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      use_imm_q <= use_imm_d;
    end
  end

  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic [1:0]        rs_sel, rt_sel;

  // Forwarding uses the registered addresses, so a stalled instruction keeps
  // picking up producers as they arrive in EX/MEM or MEM/WB.
  always_comb begin
    rs_fwd = rs_data_q;
    rs_sel = FWD_NONE;
    if (exMemWrEn && (exMemRd == rs_addr_q)) begin
      rs_fwd = exMemData;
      rs_sel = FWD_EXMEM;
    end else if (memWbWrEn && (memWbRd == rs_addr_q)) begin
      rs_fwd = memWbData;
      rs_sel = FWD_MEMWB;
    end
  end

  always_comb begin
    rt_fwd = rt_data_q;
    rt_sel = FWD_NONE;
    if (exMemWrEn && (exMemRd == rt_addr_q)) begin
      rt_fwd = exMemData;
      rt_sel = FWD_EXMEM;
    end else if (memWbWrEn && (memWbRd == rt_addr_q)) begin
      rt_fwd = memWbData;
      rt_sel = FWD_MEMWB;
    end
  end

  // Only the low nibble of Rt is a shift amount.
  logic unused_rt_hi;
  assign unused_rt_hi = ^rt_fwd[DATA_W-1:4];

  always_comb begin
    outValid = valid_q;
    shData   = '0;
    shAmount = '0;
    shOp     = '0;
    outRd    = '0;
    fwdSel   = '0;
    if (valid_q) begin
      shData   = rs_fwd;
      shAmount = use_imm_q ? imm_q : rt_fwd[3:0];
      shOp     = op_q;
      outRd    = rd_addr_q;
      fwdSel   = {rs_sel, (use_imm_q ? FWD_NONE : rt_sel)};
    end
  end

endmodule

// File: tb/tb_shift_operand_stage.sv
// Directed and randomized checks of shift_operand_stage against a
// behavioural model of the stage register and forwarding rules.
module tb_shift_operand_stage;

  logic        clk;
  logic        rst_n;
  logic        stall, flush;
  logic        inValid;
  logic [1:0]  inOp;
  logic [2:0]  inRsAddr, inRtAddr, inRdAddr;
  logic [15:0] inRsData, inRtData;
  logic [3:0]  inImm;
  logic        inUseImm;
  logic        exMemWrEn;
  logic [2:0]  exMemRd;
  logic [15:0] exMemData;
  logic        memWbWrEn;
  logic [2:0]  memWbRd;
  logic [15:0] memWbData;
  logic        outValid;
  logic [15:0] shData;
  logic [3:0]  shAmount;
  logic [1:0]  shOp;
  logic [2:0]  outRd;
  logic [3:0]  fwdSel;

  int total = 0;
  int bad   = 0;

  shift_operand_stage #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .inValid(inValid), .inOp(inOp), .inRsAddr(inRsAddr), .inRtAddr(inRtAddr),
    .inRdAddr(inRdAddr), .inRsData(inRsData), .inRtData(inRtData),
    .inImm(inImm), .inUseImm(inUseImm),
    .exMemWrEn(exMemWrEn), .exMemRd(exMemRd), .exMemData(exMemData),
    .memWbWrEn(memWbWrEn), .memWbRd(memWbRd), .memWbData(memWbData),
    .outValid(outValid), .shData(shData), .shAmount(shAmount), .shOp(shOp),
    .outRd(outRd), .fwdSel(fwdSel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: the instruction currently held by the stage.
  typedef struct packed {
    logic        v;
    logic [1:0]  op;
    logic [2:0]  rs, rt, rd;
    logic [15:0] rsd, rtd;
    logic [3:0]  imm;
    logic        ui;
  } instr_t;
  instr_t m;

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] resolve(input logic [2:0] a, input logic [15:0] regval);
    if (exMemWrEn && exMemRd == a) return {2'd2, exMemData};
    if (memWbWrEn && memWbRd == a) return {2'd1, memWbData};
    return {2'd0, regval};
  endfunction

  task automatic check(input string tag);
    logic [17:0] rsr, rtr;
    logic [15:0] e_data;
    logic [3:0]  e_amt, e_sel;
    logic [1:0]  e_op;
    logic [2:0]  e_rd;
    #1;
    rsr = resolve(m.rs, m.rsd);
    rtr = resolve(m.rt, m.rtd);
    e_data = m.v ? rsr[15:0] : 16'h0;
    e_amt  = !m.v ? 4'h0 : (m.ui ? m.imm : rtr[3:0]);
    e_op   = m.v ? m.op : 2'b00;
    e_rd   = m.v ? m.rd : 3'b000;
    e_sel  = !m.v ? 4'h0 : {rsr[17:16], (m.ui ? 2'b00 : rtr[17:16])};
    cmp({tag, ".valid"}, {15'b0, outValid}, {15'b0, m.v});
    cmp({tag, ".data"},  shData, e_data);
    cmp({tag, ".amt"},   {12'b0, shAmount}, {12'b0, e_amt});
    cmp({tag, ".op"},    {14'b0, shOp}, {14'b0, e_op});
    cmp({tag, ".rd"},    {13'b0, outRd}, {13'b0, e_rd});
    cmp({tag, ".fwd"},   {12'b0, fwdSel}, {12'b0, e_sel});
    $display("check %-10s v=%0d data=%h amt=%h op=%0d rd=%0d fwd=%b", tag,
             outValid, shData, shAmount, shOp, outRd, fwdSel);
  endtask

  // Advance one clock; the model captures the inputs seen at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      if (flush) m.v = 1'b0;
      else if (!stall)
        m = '{v:inValid, op:inOp, rs:inRsAddr, rt:inRtAddr, rd:inRdAddr,
              rsd:inRsData, rtd:inRtData, imm:inImm, ui:inUseImm};
    end
    #1;
  endtask

  task automatic idle();
    stall = 0; flush = 0; inValid = 0; inOp = 0;
    inRsAddr = 0; inRtAddr = 0; inRdAddr = 0; inRsData = 0; inRtData = 0;
    inImm = 0; inUseImm = 0;
    exMemWrEn = 0; exMemRd = 0; exMemData = 0;
    memWbWrEn = 0; memWbRd = 0; memWbData = 0;
  endtask

  task automatic load(input logic [1:0] op, input logic [2:0] rs, input logic [2:0] rt,
                      input logic [2:0] rd, input logic [15:0] rsd, input logic [15:0] rtd,
                      input logic ui, input logic [3:0] imm);
    inValid = 1; inOp = op; inRsAddr = rs; inRtAddr = rt; inRdAddr = rd;
    inRsData = rsd; inRtData = rtd; inUseImm = ui; inImm = imm;
    tick();
    inValid = 0;
  endtask

  initial begin
    idle();
    m = '0;
    rst_n = 0;
    #12;
    check("reset");
    rst_n = 1;
    tick();
    check("post_rst");

    // Plain capture with immediate amount
    load(2'b01, 3'd1, 3'd2, 3'd5, 16'h00F3, 16'h1234, 1'b1, 4'd4);
    check("capture");
    cmp("cap_data", shData, 16'h00F3);
    cmp("cap_amt", {12'b0, shAmount}, 16'd4);
    cmp("cap_fwd", {12'b0, fwdSel}, 16'h0000);

    // EX/MEM wins over MEM/WB on Rs; MEM/WB feeds Rt
    load(2'b00, 3'd2, 3'd3, 3'd1, 16'h1111, 16'h2222, 1'b0, 4'd0);
    exMemWrEn = 1; exMemRd = 3'd2; exMemData = 16'hA5A5;
    memWbWrEn = 1; memWbRd = 3'd2; memWbData = 16'h1237;
    check("prio_rs");
    cmp("prio_data", shData, 16'hA5A5);
    memWbRd = 3'd3;
    check("prio_rt");
    cmp("prio_amt", {12'b0, shAmount}, 16'd7);
    cmp("prio_sel", {12'b0, fwdSel}, 16'b1001);
    idle();

    // Stall holds the instruction; forwarding still tracks producers
    load(2'b10, 3'd4, 3'd6, 3'd6, 16'h8001, 16'h0000, 1'b1, 4'd1);
    check("stall_0");
    for (int i = 0; i < 3; i++) begin
      stall = 1;
      inValid = 1; inOp = 2'($urandom); inRsAddr = 3'($urandom);
      inRsData = 16'($urandom); inImm = 4'($urandom); inRdAddr = 3'($urandom);
      if (i == 1) begin
        exMemWrEn = 1; exMemRd = 3'd4; exMemData = 16'h0F0F;
        check("stall_fwd");
        cmp("stall_fwd_data", shData, 16'h0F0F);
        exMemWrEn = 0;
      end
      tick();
      check("stall_hold");
      cmp("stall_data", shData, 16'h8001);
      cmp("stall_op", {14'b0, shOp}, 16'd2);
    end
    idle();

    // Flush beats stall
    load(2'b11, 3'd1, 3'd1, 3'd2, 16'hBEEF, 16'h0005, 1'b0, 4'd0);
    check("pre_flush");
    flush = 1; stall = 1;
    tick();
    idle();
    check("flushed");
    cmp("flush_valid", {15'b0, outValid}, 16'd0);
    cmp("flush_data", shData, 16'h0000);
    load(2'b01, 3'd7, 3'd0, 3'd3, 16'h4321, 16'h0009, 1'b0, 4'd0);
    check("resume");
    cmp("resume_data", shData, 16'h4321);

    // Immediate amount ignores an Rt producer
    load(2'b00, 3'd0, 3'd5, 3'd4, 16'h0F00, 16'h000A, 1'b1, 4'd15);
    exMemWrEn = 1; exMemRd = 3'd5; exMemData = 16'h0003;
    check("imm_rt");
    cmp("imm_amt", {12'b0, shAmount}, 16'd15);
    cmp("imm_rtsel", {14'b0, fwdSel[1:0]}, 16'd0);
    idle();

    // Asynchronous reset mid-cycle while valid
    load(2'b01, 3'd3, 3'd3, 3'd7, 16'h7777, 16'h0002, 1'b0, 4'd0);
    #2;
    rst_n = 0;
    m = '0;
    check("async_rst");
    cmp("arst_data", shData, 16'h0000);
    cmp("arst_rd", {13'b0, outRd}, 16'd0);
    rst_n = 1;
    tick();
    check("arst_idle");

    // Randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 9) == 0);
      inValid = 1'($urandom); inOp = 2'($urandom);
      inRsAddr = 3'($urandom); inRtAddr = 3'($urandom); inRdAddr = 3'($urandom);
      inRsData = 16'($urandom); inRtData = 16'($urandom);
      inImm = 4'($urandom); inUseImm = 1'($urandom);
      exMemWrEn = 1'($urandom); memWbWrEn = 1'($urandom);
      exMemRd = $urandom_range(0, 1) ? m.rs : 3'($urandom);
      memWbRd = $urandom_range(0, 1) ? m.rt : 3'($urandom);
      if ($urandom_range(0, 3) == 0) memWbRd = m.rs;
      exMemData = 16'($urandom); memWbData = 16'($urandom);
      check("rand");
      tick();
    end
    idle();
    check("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
